// File: rtl/bht_update_queue_pkg.sv
// Shared types for the resolved-branch update queue feeding the gshare BHT.
package bht_update_queue_pkg;

    localparam int unsigned VLEN = 64;

    // Update record handed to the BHT.
    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

    // One buffered resolved-branch outcome.
    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic            taken;
        logic            mispred;
    } brq_entry_t;

    // Build a valid BHT update from a queue entry.
    function automatic bht_update_t make_update(input brq_entry_t e);
        bht_update_t u;
        u.valid = 1'b1;
        u.pc    = e.pc;
        u.taken = e.taken;
        return u;
    endfunction

endpackage

// File: rtl/bht_update_queue_fifo.sv
// Small in-order FIFO with synchronous flush; pointers wrap naturally (DEPTH is a power of 2).
module bht_update_queue_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         dtype = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic testmode_i,
    input  logic push_i,
    input  dtype data_i,
    input  logic pop_i,
    output dtype data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    dtype              mem_q [DEPTH];
    logic              push_ok;
    logic              pop_ok;
    logic              unused_testmode;

    // No clock gating here, so test mode has no effect.
    assign unused_testmode = testmode_i;

    // Status and head-of-queue view.
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Pointer, occupancy and storage update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/bht_update_queue.sv
// Buffers resolved-branch outcomes in order and issues one BHT update per cycle;
// a mispredicted update is followed by a one-cycle FTQ flush pulse.
module bht_update_queue
    import bht_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DROP_CNT_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  debug_mode_i,
    input  logic                  resolve_valid_i,
    input  logic [VLEN-1:0]       resolve_pc_i,
    input  logic                  resolve_taken_i,
    input  logic                  resolve_mispred_i,
    output logic                  resolve_ready_o,
    output bht_update_t           bht_update_o,
    output logic                  flush_ftq_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    typedef enum logic [0:0] {
        RUN       = 1'b0,
        FTQ_FLUSH = 1'b1
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  drop;
    logic                  pop;
    brq_entry_t            push_entry;
    brq_entry_t            head;
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    // Pushes are never back-pressured; a full queue drops and counts instead.
    assign push = resolve_valid_i & ~full & ~flush_i;
    assign drop = resolve_valid_i & full & ~flush_i;

    assign push_entry.pc      = resolve_pc_i;
    assign push_entry.taken   = resolve_taken_i;
    assign push_entry.mispred = resolve_mispred_i;

    assign resolve_ready_o = ~full;
    assign drop_cnt_o      = drop_cnt_q;

    bht_update_queue_fifo #(
        .DEPTH (DEPTH),
        .dtype (brq_entry_t)
    ) i_fifo (
        .clk_i      (clk_i),
        .rst_ni     (~rst_i),
        .flush_i    (flush_i),
        .testmode_i (1'b0),
        .push_i     (push),
        .data_i     (push_entry),
        .pop_i      (pop),
        .data_o     (head),
        .full_o     (full),
        .empty_o    (empty)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue from the head and sequence the post-mispredict FTQ flush pulse.
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        flush_ftq_o  = 1'b0;
        bht_update_o = '0;
        case (state_q)
            RUN: begin
                if (!empty && !debug_mode_i && !flush_i) begin
                    pop          = 1'b1;
                    bht_update_o = make_update(head);
                    if (head.mispred) begin
                        state_d = FTQ_FLUSH;
                    end
                end
            end
            FTQ_FLUSH: begin
                flush_ftq_o = 1'b1;
                state_d     = RUN;
            end
        endcase
    end

    // Saturating count of outcomes lost to a full queue; only reset clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
        end
    end

endmodule
